// File: rtl/mem_arb_pkg.sv
// Shared types for the unified I/D memory port arbiter.
// State and op encodings plus the latched request bundle.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
      op_e         op;
      logic        bad;
   } req_t;

   function automatic int cnt_w(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_req_latch.sv
// Holds the granted request so the memory port ignores
// requester changes while a transaction is in flight.
module mem_req_latch
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic ld_i,
   input  req_t req_i,
   output req_t req_o
);

   req_t req_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q <= '0;
      end else if (ld_i) begin
         req_q <= req_i;
      end
   end

   assign req_o = req_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (I) and memory-stage (D) requests onto one
// mem_system port; D wins ties, bounded by a starvation counter.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iRd,
   input  logic [15:0] iAddr,
   output logic [15:0] iDataOut,
   output logic        iDone,
   output logic        iErr,
   input  logic        dRd,
   input  logic        dWr,
   input  logic [15:0] dAddr,
   input  logic [15:0] dDataIn,
   output logic [15:0] dDataOut,
   output logic        dDone,
   output logic        dErr,
   output logic [15:0] mAddr,
   output logic [15:0] mDataIn,
   output logic        mRd,
   output logic        mWr,
   input  logic [15:0] mDataOut,
   input  logic        mDone,
   input  logic        mErr,
   output logic        grantI,
   output logic        grantD
);

   localparam int CW = cnt_w(STARVE_LIMIT);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ld;
   logic          pick_i;
   logic          d_req;
   logic          tie;
   logic          force_i;
   logic          fin;
   logic          busy;
   req_t          req_in;
   req_t          req_cur;

   assign d_req   = dRd | dWr;
   assign tie     = iRd & d_req;
   assign force_i = (STARVE_LIMIT != 0) && (cnt_q == LIM);
   assign fin     = mDone | mErr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ld      = 1'b0;
      pick_i  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tie) begin
               ld     = 1'b1;
               pick_i = force_i;
               if (force_i) begin
                  state_d = BUSY_I;
                  cnt_d   = '0;
               end else begin
                  state_d = BUSY_D;
                  if (cnt_q != LIM) begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end else if (d_req) begin
               ld      = 1'b1;
               state_d = BUSY_D;
            end else if (iRd) begin
               ld      = 1'b1;
               pick_i  = 1'b1;
               state_d = BUSY_I;
               cnt_d   = '0;
            end
         end
         BUSY_I, BUSY_D: begin
            if (fin) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read+write together from D performs the write but flags an error.
   always_comb begin
      req_in = '0;
      if (pick_i) begin
         req_in.addr = iAddr;
         req_in.op   = OP_RD;
      end else begin
         req_in.addr = dAddr;
         req_in.data = dDataIn;
         req_in.op   = dWr ? OP_WR : OP_RD;
         req_in.bad  = dRd & dWr;
      end
   end

   mem_req_latch u_latch (
      .clk   (clk),
      .rst_n (rst),
      .ld_i  (ld),
      .req_i (req_in),
      .req_o (req_cur)
   );

   assign grantI = (state_q == BUSY_I);
   assign grantD = (state_q == BUSY_D);
   assign busy   = grantI | grantD;

   assign mRd     = busy && (req_cur.op == OP_RD);
   assign mWr     = busy && (req_cur.op == OP_WR);
   assign mAddr   = req_cur.addr;
   assign mDataIn = req_cur.data;

   assign iDone = grantI & fin;
   assign iErr  = grantI & mErr;
   assign dDone = grantD & fin;
   assign dErr  = grantD & (mErr | (mDone & req_cur.bad));

   assign iDataOut = iDone ? mDataOut : '0;
   assign dDataOut = dDone ? mDataOut : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one `mem_system` instance between the fetch stage (I-port, read-only) and the memory stage (D-port, read/write), enabling a unified instruction/data memory. Arbitrates level-held requests, latches the winning request, holds it on the memory port until `Done`, then routes `Done`, read data and `err` back to the owner. D-port wins ties for pipeline ordering. A starvation counter bounds how long fetch can be locked out.

## Interface
- `STARVE_LIMIT`, 4: consecutive tie losses by I-port before it is forced to win; 0 means pure D priority with no forcing.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `iRd` in 1: fetch read request; held until `iDone`.
- `iAddr` in 16: fetch address.
- `iDataOut` out 16: fetch read data; valid with `iDone`.
- `iDone` out 1: fetch completion pulse.
- `iErr` out 1: fetch error pulse.
- `dRd` in 1: data read request; held until `dDone`.
- `dWr` in 1: data write request; held until `dDone`.
- `dAddr` in 16: data address.
- `dDataIn` in 16: write data.
- `dDataOut` out 16: data read data; valid with `dDone`.
- `dDone` out 1: data completion pulse.
- `dErr` out 1: data error pulse.
- `mAddr` out 16: address to `mem_system`.
- `mDataIn` out 16: write data to `mem_system`.
- `mRd` out 1: read strobe to `mem_system`.
- `mWr` out 1: write strobe to `mem_system`.
- `mDataOut` in 16: read data from `mem_system`.
- `mDone` in 1: completion from `mem_system`.
- `mErr` in 1: error from `mem_system`.
- `grantI` out 1: I-port owns the memory port (BUSY_I).
- `grantD` out 1: D-port owns the memory port (BUSY_D).

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE with no request: stay. `mRd`/`mWr` are 0.
- IDLE with one request: grant that port.
- IDLE with a tie (`iRd` and `dRd|dWr`): D wins unless `STARVE_LIMIT`≠0 and `starveCnt`==`STARVE_LIMIT`, in which case I wins.
- `starveCnt`:
  - increments, saturating, on each tie won by D;
  - clears whenever I is granted;
  - holds otherwise.
- On grant, latch address, write data and op into registers. Downstream outputs are driven only from these latches, so requester input changes mid-transaction are ignored.
- D-port with both `dRd` and `dWr` set: the write is performed, and `dErr` pulses together with `dDone`.
- BUSY_x: drive `mRd`/`mWr` from the latched op every cycle until `mDone` or `mErr`.
  - On `mDone`: owner `xDone`=1 and `xDataOut`=`mDataOut` in the same cycle (combinational pass-through gated by grant). Next state IDLE.
  - On `mErr`: owner `xErr`=1 and `xDone`=1 in the same cycle. Next state IDLE.
- Non-owner `Done`/`Err` are always 0. `xDataOut` is 0 when `xDone`=0.
- A requester that drops its request mid-transaction still gets its transaction completed, and still sees the `Done` pulse.

## Timing
- Reset values: state IDLE, `starveCnt`=0, latches 0, all outputs 0.
- Reset mid-transaction aborts immediately. `mRd`/`mWr` fall asynchronously.
- Latency: request seen in IDLE at cycle 0 → `mRd`/`mWr` high at cycle 1 → `xDone` in the same cycle as `mDone` (cycle k≥1).
- One mandatory IDLE cycle between transactions.
  - A requester still high in the cycle after its `xDone` is treated as a new request.
  - Requesters must drop their request in the `Done` cycle to avoid a repeat.
- `mDone` or `mErr` while in IDLE: ignored, no output.

## Structure
- Shared package `mem_arb_pkg`: state encoding localparams (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2) and the op encoding (OP_RD, OP_WR).
- Starvation counter width: clog2(`STARVE_LIMIT`+1), minimum 1.
- One natural sub-module: `mem_req_latch`, which holds the address, data and op registers with a load enable.
- FSM and routing stay in the top module.

## Test plan
- Lone I read, addr 0x0010, `mDone` 3 cycles after `mRd`, `mDataOut`=0xBEEF → `iDone` and `iDataOut`=0xBEEF in that cycle; `grantD`=0 throughout.
- Tie every cycle with `STARVE_LIMIT`=4, each `mDone` immediate → grant sequence D,D,D,D,I,D,… and `starveCnt` returns to 0 after the I grant.
- D write 0x1234 to 0x0040; change `dAddr`/`dDataIn` mid-transaction → `mAddr`=0x0040 and `mDataIn`=0x1234 held until `mDone`.
- `mErr` during BUSY_I → `iErr`=1 and `iDone`=1 in that cycle, `dErr`=0, next state IDLE.
- Reset asserted in BUSY_D → `mWr`, `grantD` and all outputs go to 0 without waiting for a clock edge; after release with no request, state stays IDLE.
- `dRd`=`dWr`=1 → write issued (`mWr`=1, `mRd`=0), `dErr` pulses with `dDone`.
